uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
// Without the macro, frames are 8N1 and O_PARITY_ERR is tied to 0.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       RX_SERIAL,
    output logic [7:0] O_RX_BYTE,
    output logic       O_RX_DATA_VALID,
    output logic       O_RX_BUSY,
    output logic       O_FRAME_ERR,
    output logic       O_PARITY_ERR
);

    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic [9:0] counter;
    logic [2:0] bit_idx;
    logic [7:0] rx_data;
    // Cleared by a frame error; a held-low line must go high before a new start is accepted.
    logic       armed;
`ifdef UART_RX_PARITY_EN
    logic       parity_bad;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_SERIAL;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with registered byte and single-cycle status pulses.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            counter         <= '0;
            bit_idx         <= '0;
            rx_data         <= '0;
            armed           <= 1'b1;
            O_RX_BYTE       <= '0;
            O_RX_DATA_VALID <= 1'b0;
            O_FRAME_ERR     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad      <= 1'b0;
            O_PARITY_ERR    <= 1'b0;
`endif
        end else begin
            O_RX_DATA_VALID <= 1'b0;
            O_FRAME_ERR     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            O_PARITY_ERR    <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    counter <= '0;
                    bit_idx <= '0;
                    if (!armed) begin
                        if (rx_s) armed <= 1'b1;
                    end else if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        // A start bit gone high by mid-bit was a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        counter <= counter + 10'd1;
                    end
                end
                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter          <= '0;
                        rx_data[bit_idx] <= rx_s;
                        bit_idx          <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        counter <= counter + 10'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (counter == BIT_LAST) begin
                        counter    <= '0;
                        // Even parity: data plus parity bit must hold an even number of ones.
                        parity_bad <= ^{rx_data, rx_s};
                        state      <= STOP;
                    end else begin
                        counter <= counter + 10'd1;
                    end
                end
`endif
                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                O_PARITY_ERR <= 1'b1;
                            end else begin
                                O_RX_BYTE       <= rx_data;
                                O_RX_DATA_VALID <= 1'b1;
                            end
`else
                            O_RX_BYTE       <= rx_data;
                            O_RX_DATA_VALID <= 1'b1;
`endif
                        end else begin
                            O_FRAME_ERR <= 1'b1;
                            armed       <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O_RX_BUSY = (state != IDLE);

`ifndef UART_RX_PARITY_EN
    assign O_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a frame-level reference model.
// Each driven frame pushes its expected outcome (good byte, frame error or
// parity error) and due cycle into a queue; a compare process matches pulses.
module tb_uart_rx;

    localparam int C = 8;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Pin falling edge to first cycle the pulse is visible.
    localparam int LAT = 3 + H + NBITS * C;

    localparam int K_VALID = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
        int         due;
    } ev_t;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       RX_SERIAL = 1'b1;
    logic [7:0] O_RX_BYTE;
    logic       O_RX_DATA_VALID;
    logic       O_RX_BUSY;
    logic       O_FRAME_ERR;
    logic       O_PARITY_ERR;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         nvalid = 0;
    int         nframe = 0;
    int         npar = 0;
    logic [7:0] model_byte = 8'h00;
    ev_t        expq[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .RX_SERIAL      (RX_SERIAL),
        .O_RX_BYTE      (O_RX_BYTE),
        .O_RX_DATA_VALID(O_RX_DATA_VALID),
        .O_RX_BUSY      (O_RX_BUSY),
        .O_FRAME_ERR    (O_FRAME_ERR),
        .O_PARITY_ERR   (O_PARITY_ERR)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Compare DUT outputs against the frame-level model on every falling edge.
    always @(negedge CLOCK) begin : cmp
        int  n;
        int  k;
        ev_t ev;
        n = int'(O_RX_DATA_VALID) + int'(O_FRAME_ERR) + int'(O_PARITY_ERR);
        if (n != 0) begin
            check("pulse_exclusive", n, 1);
            k = O_RX_DATA_VALID ? K_VALID : (O_FRAME_ERR ? K_FRAME : K_PAR);
            if (k == K_VALID) nvalid++;
            else if (k == K_FRAME) nframe++;
            else npar++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected no pulse", k, cyc);
            end else begin
                ev = expq.pop_front();
                check("pulse_kind", k, ev.kind);
                checks++;
                if (cyc < ev.due - 1 || cyc > ev.due + 1) begin
                    errors++;
                    $display("FAIL pulse_latency: pulse at cycle %0d, expected %0d +-1", cyc, ev.due);
                end
                if (ev.kind == K_VALID) model_byte = ev.b;
            end
        end
        check("rx_byte", int'(O_RX_BYTE), int'(model_byte));
        if (expq.size() > 0 && cyc > expq[0].due + 1) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: kind %0d due at cycle %0d, none by cycle %0d",
                     expq[0].kind, expq[0].due, cyc);
            void'(expq.pop_front());
        end
    end

    // Inputs change 1 time unit after a rising edge; every task starts and ends there.
    task automatic settle(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RX_SERIAL = v;
        settle(C);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic par_ok, input int gap);
        ev_t ev;
        ev.b    = b;
        ev.due  = cyc + LAT;
        ev.kind = !stop ? K_FRAME : (!par_ok ? K_PAR : K_VALID);
        expq.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^b : ~^b);
`endif
        drive_bit(stop);
        RX_SERIAL = 1'b1;
        if (gap > 0) settle(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte"}, int'(O_RX_BYTE), 0);
        check({tag, "_busy"}, int'(O_RX_BUSY), 0);
        check({tag, "_valid"}, int'(O_RX_DATA_VALID), 0);
        check({tag, "_frame_err"}, int'(O_FRAME_ERR), 0);
        check({tag, "_parity_err"}, int'(O_PARITY_ERR), 0);
    endtask

    initial begin
        int         start;
        int         nv;
        int         nf;
        logic [7:0] rb;
        logic       rs;
        logic       rp;

        settle(4);
        @(negedge CLOCK);
        check_all_zero("reset");
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        settle(2 * C);

        // Single good frame.
        send(8'hA5, 1'b1, 1'b1, 4);
        @(negedge CLOCK);
        check("a5_valid_count", nvalid, 1);
        check("a5_byte", int'(O_RX_BYTE), 8'hA5);
        check("a5_frame_err_count", nframe, 0);
        check("a5_busy_after", int'(O_RX_BUSY), 0);
        settle(1);

        // Back-to-back frames, no idle gap.
        send(8'h00, 1'b1, 1'b1, 0);
        send(8'hFF, 1'b1, 1'b1, 4);
        @(negedge CLOCK);
        check("b2b_valid_count", nvalid, 3);
        check("b2b_byte", int'(O_RX_BYTE), 8'hFF);
        settle(1);

        // Two-cycle glitch on an idle line.
        start = cyc;
        RX_SERIAL = 1'b0;
        settle(2);
        RX_SERIAL = 1'b1;
        while (cyc < start + 3) @(posedge CLOCK);
        @(negedge CLOCK);
        check("glitch_busy_seen", int'(O_RX_BUSY), 1);
        while (cyc < start + 3 + H) @(posedge CLOCK);
        @(negedge CLOCK);
        check("glitch_busy_cleared", int'(O_RX_BUSY), 0);
        settle(2 * C);
        check("glitch_no_pulse", nvalid + nframe + npar, 3);

        // Stop bit low: frame error, byte held.
        send(8'h3C, 1'b0, 1'b1, 4);
        @(negedge CLOCK);
        check("stop_low_frame_err_count", nframe, 1);
        check("stop_low_valid_count", nvalid, 3);
        check("stop_low_byte_held", int'(O_RX_BYTE), 8'hFF);
        settle(1);

        // Break: one frame error, no re-trigger until the line returns high.
        begin
            ev_t ev;
            ev.kind = K_FRAME;
            ev.b    = 8'h00;
            ev.due  = cyc + LAT;
            expq.push_back(ev);
        end
        RX_SERIAL = 1'b0;
        settle(20 * C);
        RX_SERIAL = 1'b1;
        settle(2 * C);
        check("break_frame_err_count", nframe, 2);
        check("break_busy_after", int'(O_RX_BUSY), 0);
        send(8'h81, 1'b1, 1'b1, 4);
        check("after_break_byte", int'(O_RX_BYTE), 8'h81);

        // Reset during data bit 4, then a clean frame.
        RX_SERIAL = 1'b0;
        settle(C);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        RX_SERIAL = 1'b1;
        settle(H);
        RESET_N = 1'b0;
        expq.delete();
        model_byte = 8'h00;
        @(negedge CLOCK);
        check_all_zero("midreset");
        settle(3);
        @(negedge CLOCK);
        check_all_zero("midreset_hold");
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        settle(2 * C);
        nv = nvalid;
        send(8'h55, 1'b1, 1'b1, 4);
        check("post_reset_valid_count", nvalid - nv, 1);
        check("post_reset_byte", int'(O_RX_BYTE), 8'h55);

`ifdef UART_RX_PARITY_EN
        // Parity: wrong parity bit, then correct parity bit.
        nv = nvalid;
        send(8'h07, 1'b1, 1'b0, 4);
        check("parity_wrong_err_count", npar, 1);
        check("parity_wrong_no_valid", nvalid - nv, 0);
        check("parity_wrong_byte_held", int'(O_RX_BYTE), 8'h55);
        send(8'h07, 1'b1, 1'b1, 4);
        check("parity_ok_valid", nvalid - nv, 1);
        check("parity_ok_byte", int'(O_RX_BYTE), 8'h07);
        // Both parity and stop bad: frame error only.
        nf = nframe;
        send(8'h07, 1'b0, 1'b0, 4);
        check("parity_and_stop_frame_only", nframe - nf, 1);
        check("parity_and_stop_no_par", npar, 1);
`endif

        // Randomized frames with random gaps, bad stop bits and bad parity.
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            rp = ($urandom_range(0, 3) != 0);
`else
            rp = 1'b1;
`endif
            send(rb, rs, rp, rs ? $urandom_range(0, C) : $urandom_range(2, C));
        end

        settle(LAT + 10);
        check("queue_drained", expq.size(), 0);
        check("final_busy", int'(O_RX_BUSY), 0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_never", npar, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
